ysyx_lsu_ctrl: RTL and testbench

//  Load/store unit controller between the EXU and the bus arbiter's lsu:load / lsu:store ports.

---
 rtl/ysyx_lsu_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ysyx_lsu_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_lsu_ctrl.sv
// Load/store unit controller: one memory op at a time, EXU request -> arbiter lsu:load/lsu:store -> one-cycle response.
// Optional build macro YSYX_LSU_ALIGN_CHECK_EN enables the misalignment fault path (rsp_err_o).
module ysyx_lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready_o,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] lsu_araddr_o,
  output logic              lsu_arvalid_o,
  output logic [7:0]        lsu_rstrb_o,
  input  logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rvalid,
  output logic [ADDR_W-1:0] lsu_awaddr_o,
  output logic              lsu_awvalid_o,
  output logic [DATA_W-1:0] lsu_wdata_o,
  output logic [7:0]        lsu_wstrb_o,
  output logic              lsu_wvalid_o,
  input  logic              lsu_wready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Access size from funct3; the undefined encodings fall back to a word access.
  function automatic logic [1:0] f_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: f_size = SZ_BYTE;
      3'b001, 3'b101: f_size = SZ_HALF;
      default:        f_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [7:0] f_strb(input logic [1:0] size);
    case (size)
      SZ_BYTE: f_strb = 8'h01;
      SZ_HALF: f_strb = 8'h03;
      default: f_strb = 8'h0f;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_extend(input logic [2:0] f3, input logic [DATA_W-1:0] d);
    case (f3)
      3'b000:  f_extend = {{(DATA_W-8){d[7]}}, d[7:0]};
      3'b001:  f_extend = {{(DATA_W-16){d[15]}}, d[15:0]};
      3'b100:  f_extend = {{(DATA_W-8){1'b0}}, d[7:0]};
      3'b101:  f_extend = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: f_extend = d;
    endcase
  endfunction

`ifdef YSYX_LSU_ALIGN_CHECK_EN
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_HALF: f_misaligned = a[0];
      SZ_WORD: f_misaligned = |a;
      default: f_misaligned = 1'b0;
    endcase
  endfunction
`endif

  logic [1:0]        r_state;
  logic              r_req_ready;
  logic              r_arvalid;
  logic              r_awvalid;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_araddr;
  logic [ADDR_W-1:0] r_awaddr;
  logic [7:0]        r_rstrb;
  logic [7:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;

  logic [1:0]        w_size;
  logic [7:0]        w_strb;
  logic              w_misalign;
  logic              w_accept;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;

  // Decode of the incoming request (size, strobe, alignment fault).
  always_comb begin
    w_size = f_size(req_funct3);
    w_strb = f_strb(w_size);
`ifdef YSYX_LSU_ALIGN_CHECK_EN
    w_misalign = f_misaligned(w_size, req_addr[1:0]);
`else
    w_misalign = 1'b0;
`endif
  end

  // Next-state logic; a faulting request skips the bus and goes straight to RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_misalign) begin
            w_state_nxt = S_RESP;
          end else if (req_wen) begin
            w_state_nxt = S_STORE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (lsu_rvalid) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_STORE: begin
        if (lsu_wready) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_STORE;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response data: loads capture extended bus data, stores and faults return zero, otherwise hold.
  always_comb begin
    w_rdata_nxt = r_rsp_rdata;
    if ((r_state == S_LOAD) && lsu_rvalid) begin
      w_rdata_nxt = f_extend(r_funct3, lsu_rdata);
    end else if (((r_state == S_STORE) && lsu_wready) || (w_accept && w_misalign)) begin
      w_rdata_nxt = {DATA_W{1'b0}};
    end else begin
      w_rdata_nxt = r_rsp_rdata;
    end
  end

  // Control state and handshake outputs, all registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_arvalid   <= 1'b0;
      r_awvalid   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_arvalid   <= (w_state_nxt == S_LOAD);
      r_awvalid   <= (w_state_nxt == S_STORE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_rsp_err   <= w_accept & w_misalign;
      r_rsp_rdata <= w_rdata_nxt;
    end
  end

  // Bus-side request registers: loaded once at accept and held for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_araddr <= {ADDR_W{1'b0}};
      r_awaddr <= {ADDR_W{1'b0}};
      r_rstrb  <= 8'h00;
      r_wstrb  <= 8'h00;
      r_wdata  <= {DATA_W{1'b0}};
      r_funct3 <= 3'b000;
    end else if (w_accept && !w_misalign) begin
      r_funct3 <= req_funct3;
      if (req_wen) begin
        r_awaddr <= req_addr;
        r_wstrb  <= w_strb;
        r_wdata  <= req_wdata;
      end else begin
        r_araddr <= req_addr;
        r_rstrb  <= w_strb;
      end
    end else begin
      r_araddr <= r_araddr;
      r_awaddr <= r_awaddr;
      r_rstrb  <= r_rstrb;
      r_wstrb  <= r_wstrb;
      r_wdata  <= r_wdata;
      r_funct3 <= r_funct3;
    end
  end

  assign req_ready_o   = r_req_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign lsu_araddr_o  = r_araddr;
  assign lsu_arvalid_o = r_arvalid;
  assign lsu_rstrb_o   = r_rstrb;
  assign lsu_awaddr_o  = r_awaddr;
  assign lsu_awvalid_o = r_awvalid;
  assign lsu_wvalid_o  = r_awvalid;
  assign lsu_wdata_o   = r_wdata;
  assign lsu_wstrb_o   = r_wstrb;

endmodule

// File: tb/tb_ysyx_lsu_ctrl.sv
// Self-checking bench for ysyx_lsu_ctrl: per-op timeline model, per-cycle compare, directed and random ops.
module tb_ysyx_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] lsu_araddr_o;
  logic        lsu_arvalid_o;
  logic [7:0]  lsu_rstrb_o;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr_o;
  logic        lsu_awvalid_o;
  logic [31:0] lsu_wdata_o;
  logic [7:0]  lsu_wstrb_o;
  logic        lsu_wvalid_o;
  logic        lsu_wready;

  always #5 clk = ~clk;

  ysyx_lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready_o(req_ready_o), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .lsu_araddr_o(lsu_araddr_o), .lsu_arvalid_o(lsu_arvalid_o), .lsu_rstrb_o(lsu_rstrb_o),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr_o(lsu_awaddr_o), .lsu_awvalid_o(lsu_awvalid_o), .lsu_wdata_o(lsu_wdata_o),
    .lsu_wstrb_o(lsu_wstrb_o), .lsu_wvalid_o(lsu_wvalid_o), .lsu_wready(lsu_wready)
  );

`ifdef YSYX_LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs for the current cycle, set by the stimulus from the op timeline.
  logic        exp_ready, exp_arv, exp_awv, exp_rsp, exp_err;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [7:0]  exp_strb;

  // Monitor state, written only by the monitor process.
  int        arv_cnt = 0, awv_cnt = 0, rsp_cnt = 0;
  logic [7:0] last_rstrb = 8'h00, last_wstrb = 8'h00;
  logic       last_err = 1'b0;

  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] f3);
    int n;
    n = size_bytes(f3);
    return (n == 1) ? 8'h01 : (n == 2) ? 8'h03 : 8'h0f;
  endfunction

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] addr);
    return ALIGN_EN && ((addr % size_bytes(f3)) != 32'd0);
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] raw);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = raw % 32'd256;   return (v >= 32'd128)   ? v + 32'hFFFFFF00 : v; end
      3'd1: begin v = raw % 32'd65536; return (v >= 32'd32768) ? v + 32'hFFFF0000 : v; end
      3'd4: return raw % 32'd256;
      3'd5: return raw % 32'd65536;
      default: return raw;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("req_ready", {31'd0, req_ready_o}, {31'd0, exp_ready});
    check("arvalid", {31'd0, lsu_arvalid_o}, {31'd0, exp_arv});
    check("awvalid", {31'd0, lsu_awvalid_o}, {31'd0, exp_awv});
    check("wvalid", {31'd0, lsu_wvalid_o}, {31'd0, exp_awv});
    check("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, exp_rsp});
    check("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
    check("rsp_rdata", rsp_rdata_o, exp_rdata);
    if (exp_arv) begin
      check("araddr", lsu_araddr_o, exp_addr);
      check("rstrb", {24'd0, lsu_rstrb_o}, {24'd0, exp_strb});
    end
    if (exp_awv) begin
      check("awaddr", lsu_awaddr_o, exp_addr);
      check("wdata", lsu_wdata_o, exp_wdata);
      check("wstrb", {24'd0, lsu_wstrb_o}, {24'd0, exp_strb});
    end
  end

  always @(negedge clk) begin
    if (lsu_arvalid_o) begin arv_cnt <= arv_cnt + 1; last_rstrb <= lsu_rstrb_o; end
    if (lsu_awvalid_o) begin awv_cnt <= awv_cnt + 1; last_wstrb <= lsu_wstrb_o; end
    if (rsp_valid_o)   begin rsp_cnt <= rsp_cnt + 1; last_err <= rsp_err_o; end
  end

  task automatic set_exp(input logic rdy, input logic arv, input logic awv, input logic rsp, input logic err);
    exp_ready = rdy; exp_arv = arv; exp_awv = awv; exp_rsp = rsp; exp_err = err;
  endtask

  task automatic noise_req();
    req_valid  = 1'($urandom_range(0, 1));
    req_wen    = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic set_reset_exp();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_rdata = 32'd0;
  endtask

  task automatic idle_cycle();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req_valid  = 1'b0;
    lsu_rvalid = 1'($urandom_range(0, 1));
    lsu_wready = 1'($urandom_range(0, 1));
    lsu_rdata  = $urandom;
    @(posedge clk); #1;
  endtask

  // One op from an IDLE cycle through its response; returns in the following IDLE cycle.
  task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] raw, input int wait_n);
    logic mis;
    mis = is_mis(f3, addr);
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    lsu_rvalid = 1'($urandom_range(0, 1));
    lsu_wready = 1'($urandom_range(0, 1));
    lsu_rdata  = $urandom;
    @(posedge clk); #1;
    if (!mis) begin
      for (int k = 0; k <= wait_n; k++) begin
        set_exp(1'b0, !wen, wen, 1'b0, 1'b0);
        exp_addr = addr; exp_wdata = wdata; exp_strb = model_strb(f3);
        noise_req();
        lsu_rvalid = wen ? 1'($urandom_range(0, 1)) : (k == wait_n);
        lsu_wready = wen ? (k == wait_n) : 1'($urandom_range(0, 1));
        lsu_rdata  = (k == wait_n) ? raw : $urandom;
        @(posedge clk); #1;
      end
    end
    set_exp(1'b0, 1'b0, 1'b0, 1'b1, mis);
    exp_rdata  = (mis || wen) ? 32'd0 : model_ext(f3, raw);
    noise_req();
    lsu_rvalid = 1'($urandom_range(0, 1));
    lsu_wready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b0;
  endtask

  initial begin
    int a0, w0, r0;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    rst = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    lsu_rdata = 32'd0; lsu_rvalid = 1'b0; lsu_wready = 1'b0;
    set_reset_exp();
    exp_addr = 32'd0; exp_wdata = 32'd0; exp_strb = 8'h00;
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", {31'd0, req_ready_o}, 32'd1);

    // LB of 0x80 after four wait cycles
    a0 = arv_cnt;
    run_op(1'b0, 3'b000, 32'h80000003, 32'd0, 32'h00000080, 4);
    check("lb_rdata", rsp_rdata_o, 32'hFFFFFF80);
    check("lb_arvalid_cycles", arv_cnt - a0, 32'd5);
    check("lb_rstrb", {24'd0, last_rstrb}, 32'h01);

    run_op(1'b0, 3'b101, 32'h80000002, 32'd0, 32'h0000BEEF, 1);
    check("lhu_rdata", rsp_rdata_o, 32'h0000BEEF);
    check("lhu_rstrb", {24'd0, last_rstrb}, 32'h03);
    run_op(1'b0, 3'b001, 32'h80000002, 32'd0, 32'h0000BEEF, 0);
    check("lh_rdata", rsp_rdata_o, 32'hFFFFBEEF);

    w0 = awv_cnt; r0 = rsp_cnt;
    run_op(1'b1, 3'b010, 32'h80001000, 32'hDEADBEEF, 32'd0, 2);
    check("sw_awvalid_cycles", awv_cnt - w0, 32'd3);
    check("sw_wstrb", {24'd0, last_wstrb}, 32'h0f);
    check("sw_rsp_pulses", rsp_cnt - r0, 32'd1);
    check("sw_rdata_zero", rsp_rdata_o, 32'd0);

    // Misaligned word load
    a0 = arv_cnt;
    run_op(1'b0, 3'b010, 32'h80000002, 32'd0, 32'h12345678, 1);
`ifdef YSYX_LSU_ALIGN_CHECK_EN
    check("mis_no_arvalid", arv_cnt - a0, 32'd0);
    check("mis_err", {31'd0, last_err}, 32'd1);
    check("mis_rdata", rsp_rdata_o, 32'd0);
`else
    check("mis_arvalid_cycles", arv_cnt - a0, 32'd2);
    check("mis_err", {31'd0, last_err}, 32'd0);
    check("mis_rdata", rsp_rdata_o, 32'h12345678);
`endif

    // Reset in the middle of a load
    r0 = rsp_cnt;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000040;
    lsu_rvalid = 1'b0; lsu_wready = 1'b0;
    @(posedge clk); #1;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_addr = 32'h80000040; exp_strb = 8'h0f;
    req_valid = 1'b0;
    @(posedge clk); #3;
    set_reset_exp();
    rst = 1'b0;
    #1;
    check("rst_arvalid_drop", {31'd0, lsu_arvalid_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_no_rsp", rsp_cnt - r0, 32'd0);

    // Randomized ops with random wait states, idle gaps and bus noise
    for (int i = 0; i < 300; i++) begin
      wen = 1'($urandom_range(0, 1));
      if (wen) begin
        case ($urandom_range(0, 5))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
          3: f3 = 3'b011; 4: f3 = 3'b110; default: f3 = 3'b111;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom;
      run_op(wen, f3, addr, $urandom, $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    repeat (2) idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
